// File: rtl/tucanos_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tucanos_sched_pkg
//  Description : Shared definitions for the Tucanos round-robin scheduler.
//                It holds the opcodes the scheduler reacts to, the FSM state
//                encoding, the event codes reported to the OS dispatcher and
//                the per-process status encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tucanos_sched_pkg;

    // Opcodes the scheduler decodes from the executing instruction.
    localparam logic [5:0] HLT   = 6'b011100;
    localparam logic [5:0] PREIO = 6'b011110;

    // Scheduler FSM. WAIT, HALT and CHANGE each last exactly one cycle and
    // request the jump into the OS.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HALT   = 3'd3,
        ST_CHANGE = 3'd4
    } sched_state_e;

    // Event codes, placed in state_register[7:4].
    localparam logic [3:0] EV_CHANGE      = 4'd1;
    localparam logic [3:0] EV_WAIT        = 4'd4;
    localparam logic [3:0] EV_HALT        = 4'd5;
    localparam logic [3:0] EV_ALL_DONE    = 4'd6;
    localparam logic [3:0] EV_ALL_BLOCKED = 4'd7;

    // Status of one user process.
    typedef enum logic [1:0] {
        READY   = 2'd0,
        BLOCKED = 2'd1,
        DONE    = 2'd2
    } proc_status_e;

    // True in the states that ask the PC unit to jump to the OS dispatcher.
    function automatic logic is_jump_state(input sched_state_e s);
        return (s == ST_WAIT) || (s == ST_HALT) || (s == ST_CHANGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tucanos_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : tucanos_scheduler_if
//  Description : Bundle between the PC/control unit (master) and the
//                scheduler (slave).
//  Signals     : opcode, program_counter, mux_system_instruction,
//                io_done_valid, io_done_pid           (master -> slave)
//                state_register, jump_enabler, current_pid,
//                ready_mask                           (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tucanos_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 12,
    parameter int NUM_PROCS  = 3
);
    logic [5:0]            opcode;
    logic [PC_WIDTH-1:0]   program_counter;
    logic                  mux_system_instruction;
    logic                  io_done_valid;
    logic [3:0]            io_done_pid;
    logic [DATA_WIDTH-1:0] state_register;
    logic                  jump_enabler;
    logic [3:0]            current_pid;
    logic [NUM_PROCS-1:0]  ready_mask;

    modport master (
        output opcode, program_counter, mux_system_instruction,
               io_done_valid, io_done_pid,
        input  state_register, jump_enabler, current_pid, ready_mask
    );

    modport slave (
        input  opcode, program_counter, mux_system_instruction,
               io_done_valid, io_done_pid,
        output state_register, jump_enabler, current_pid, ready_mask
    );
endinterface
`default_nettype wire

// File: rtl/tucanos_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : tucanos_rr_picker
//  Description : Combinational round-robin pick. Scans pids cur+1 .. NUM_PROCS,
//                wraps to 1, and checks the current pid last. A current pid of
//                0 scans from pid 1.
//  Ports       : ready_i     in  NUM_PROCS  bit i-1 = pid i is READY
//                cur_pid_i   in  4          pid running now (0 = none)
//                next_pid_o  out 4          selected pid (0 when none found)
//                found_o     out 1          a READY pid was found
//  Revision    : 1.0 - initial release
// ============================================================================
module tucanos_rr_picker #(
    parameter int NUM_PROCS = 3
) (
    input  logic [NUM_PROCS-1:0] ready_i,
    input  logic [3:0]           cur_pid_i,
    output logic [3:0]           next_pid_o,
    output logic                 found_o
);

    // Zero-extended so a full 4-bit pid can index it without width games.
    logic [15:0] ready_ext;
    assign ready_ext = 16'(ready_i);

    always_comb begin
        logic [4:0] cand;
        cand       = 5'd0;
        next_pid_o = 4'd0;
        found_o    = 1'b0;
        for (int k = 1; k <= NUM_PROCS; k++) begin
            // cur + k lands in 1 .. 2*NUM_PROCS; one subtraction wraps it.
            cand = {1'b0, cur_pid_i} + 5'(k);
            if (cand > 5'(NUM_PROCS)) begin
                cand = cand - 5'(NUM_PROCS);
            end
            if (!found_o && ready_ext[cand[3:0] - 4'd1]) begin
                found_o    = 1'b1;
                next_pid_o = cand[3:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tucanos_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tucanos_scheduler
//  Description : Preemptive round-robin process scheduler for Tucanos OS.
//                Preempts after QUANTUM user cycles, blocks a process on PREIO,
//                retires it on HLT and wakes blocked processes on I/O
//                completion. Reports an event word and a jump request to the
//                OS dispatcher.
//  Ports       : clock, reset_n (async, active low)
//                bus   tucanos_scheduler_if.slave
//                switch_count[15:0]  out, only with TUCANOS_SCHED_STATS_EN
//  Options     : `define TUCANOS_SCHED_STATS_EN adds a saturating counter of
//                CHANGE entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tucanos_scheduler
    import tucanos_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int PC_WIDTH      = 12,
    parameter int NUM_PROCS     = 3,
    parameter int QUANTUM       = 8,
    parameter int OS_BEGIN_ADDR = 256
) (
    input  logic               clock,
    input  logic               reset_n,
    tucanos_scheduler_if.slave bus
`ifdef TUCANOS_SCHED_STATS_EN
    ,
    output logic [15:0]        switch_count
`endif
);

    localparam logic [PC_WIDTH-1:0] OS_ADDR          = PC_WIDTH'(OS_BEGIN_ADDR);
    localparam logic [7:0]          LAST_SLICE_COUNT = 8'(QUANTUM - 1);

    sched_state_e state_q;
    logic [7:0]   counter_q;
    logic [3:0]   current_pid_q;
    logic [7:0]   event_q;               // {code, next pid}
    proc_status_e status_q [NUM_PROCS];
    proc_status_e status_d [NUM_PROCS];

    logic                 suspend;
    logic                 in_run;
    logic                 is_preio;
    logic                 is_hlt;
    logic                 slice_end;
    logic                 take_event;
    logic [NUM_PROCS-1:0] ready_next;
    logic [NUM_PROCS-1:0] ready_now;
    logic                 all_done_next;
    logic [3:0]           pick_pid;
    logic                 pick_found;
    logic [3:0]           event_code;
    sched_state_e         event_state;

    always_comb begin
        suspend    = !bus.mux_system_instruction || (bus.program_counter >= OS_ADDR);
        in_run     = !suspend && (state_q == ST_RUN);
        is_preio   = (bus.opcode == PREIO);
        is_hlt     = (bus.opcode == HLT);
        slice_end  = (counter_q >= LAST_SLICE_COUNT);
        take_event = in_run && (is_preio || is_hlt || slice_end);
    end

    // Next status: the I/O wake-up is applied first, so a PREIO of the same
    // pid in the same cycle overrides it. Selection sees this next view.
    always_comb begin
        all_done_next = 1'b1;
        for (int p = 0; p < NUM_PROCS; p++) begin
            status_d[p] = status_q[p];
            if (bus.io_done_valid && (bus.io_done_pid == 4'(p + 1)) &&
                (status_q[p] == BLOCKED)) begin
                status_d[p] = READY;
            end
            if (in_run && (current_pid_q == 4'(p + 1))) begin
                if (is_preio) begin
                    status_d[p] = BLOCKED;
                end else if (is_hlt) begin
                    status_d[p] = DONE;
                end
            end
            ready_next[p] = (status_d[p] == READY);
            ready_now[p]  = (status_q[p] == READY);
            all_done_next = all_done_next && (status_d[p] == DONE);
        end
    end

    tucanos_rr_picker #(
        .NUM_PROCS (NUM_PROCS)
    ) u_picker (
        .ready_i    (ready_next),
        .cur_pid_i  (current_pid_q),
        .next_pid_o (pick_pid),
        .found_o    (pick_found)
    );

    // An empty pick overrides the cause code with the OS-idle codes.
    always_comb begin
        if (is_preio) begin
            event_state = ST_WAIT;
            event_code  = EV_WAIT;
        end else if (is_hlt) begin
            event_state = ST_HALT;
            event_code  = EV_HALT;
        end else begin
            event_state = ST_CHANGE;
            event_code  = EV_CHANGE;
        end
        if (!pick_found) begin
            event_code = all_done_next ? EV_ALL_DONE : EV_ALL_BLOCKED;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            counter_q     <= 8'd0;
            current_pid_q <= 4'd0;
            event_q       <= 8'd0;
            for (int p = 0; p < NUM_PROCS; p++) begin
                status_q[p] <= READY;
            end
        end else begin
            // I/O completions are honoured even while the OS is running.
            for (int p = 0; p < NUM_PROCS; p++) begin
                status_q[p] <= status_d[p];
            end
            if (suspend) begin
                state_q   <= ST_IDLE;
                counter_q <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_RUN;
                        counter_q <= 8'd1;
                    end
                    ST_RUN: begin
                        if (take_event) begin
                            state_q       <= event_state;
                            counter_q     <= 8'd0;
                            current_pid_q <= pick_pid;
                            event_q       <= {event_code, pick_pid};
                        end else begin
                            counter_q <= counter_q + 8'd1;
                            event_q   <= 8'd0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.state_register = DATA_WIDTH'(event_q);
    assign bus.jump_enabler   = is_jump_state(state_q);
    assign bus.current_pid    = current_pid_q;
    assign bus.ready_mask     = ready_now;

`ifdef TUCANOS_SCHED_STATS_EN
    logic [15:0] switch_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_count_q <= 16'd0;
        end else if (take_event && (event_state == ST_CHANGE) &&
                     (switch_count_q != 16'hFFFF)) begin
            switch_count_q <= switch_count_q + 16'd1;
        end
    end

    assign switch_count = switch_count_q;
`endif

endmodule
`default_nettype wire
